rgb_fade_sequencer: RTL

//  Drives the board RGB LED through a fixed 8-entry colour palette. Each channel
//  is fed by a PWM generator. A fade/hold FSM schedules the three duty registers:
//  it ramps them toward the current palette target, holds, then advances to the

---
 rtl/rgb_fade_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - palette fade/hold sequencer driving three registered PWM LED channels
// The duty registers step one count per tick toward the palette target, then hold before advancing.
module rgb_fade_sequencer #(
   parameter int PWM_BITS    = 8,
   parameter int STEP_CYCLES = 4096,
   parameter int HOLD_STEPS  = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       skip,
   output logic       led_r,
   output logic       led_g,
   output logic       led_b,
   output logic [2:0] colour_idx,
   output logic       holding
);

   localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

   typedef enum logic {FADE, HOLD} state_t;

   state_t              state, state_n;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [STEP_W-1:0]   step_cnt, step_n;
   logic [HOLD_W-1:0]   hold_cnt, hold_n;
   logic [2:0]          idx_n;
   logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
   logic [PWM_BITS-1:0] duty_r_n, duty_g_n, duty_b_n;
   logic [PWM_BITS-1:0] tgt_r, tgt_g, tgt_b;
   logic [23:0]         pal;
   logic                tick;

   always_comb begin
      case (colour_idx)
         3'd0:    pal = 24'hFF0000;
         3'd1:    pal = 24'hFF8000;
         3'd2:    pal = 24'hFFFF00;
         3'd3:    pal = 24'h00FF00;
         3'd4:    pal = 24'h00FFFF;
         3'd5:    pal = 24'h0000FF;
         3'd6:    pal = 24'h8000FF;
         default: pal = 24'hFFFFFF;
      endcase
   end

   // Palette entries are 8-bit, left-aligned into the wider duty range.
   assign tgt_r = PWM_BITS'(pal[23:16]) << (PWM_BITS - 8);
   assign tgt_g = PWM_BITS'(pal[15:8])  << (PWM_BITS - 8);
   assign tgt_b = PWM_BITS'(pal[7:0])   << (PWM_BITS - 8);

   function automatic logic [PWM_BITS-1:0] approach(input logic [PWM_BITS-1:0] cur,
                                                    input logic [PWM_BITS-1:0] tgt);
      if (cur < tgt)
         return cur + PWM_BITS'(1);
      else if (cur > tgt)
         return cur - PWM_BITS'(1);
      else
         return cur;
   endfunction

   assign tick = en && (step_cnt == STEP_W'(STEP_CYCLES - 1));

   always_comb begin
      state_n  = state;
      step_n   = step_cnt;
      hold_n   = hold_cnt;
      idx_n    = colour_idx;
      duty_r_n = duty_r;
      duty_g_n = duty_g;
      duty_b_n = duty_b;
      if (en)
         step_n = tick ? '0 : step_cnt + STEP_W'(1);
      // A skip restarts the fade from whatever duties are current and swallows a same-cycle tick.
      if (skip) begin
         idx_n   = colour_idx + 3'd1;
         state_n = FADE;
         hold_n  = '0;
         step_n  = '0;
      end else if (tick) begin
         case (state)
            FADE: begin
               if (duty_r == tgt_r && duty_g == tgt_g && duty_b == tgt_b) begin
                  state_n = HOLD;
                  hold_n  = '0;
               end else begin
                  duty_r_n = approach(duty_r, tgt_r);
                  duty_g_n = approach(duty_g, tgt_g);
                  duty_b_n = approach(duty_b, tgt_b);
               end
            end
            default: begin
               if (hold_cnt == HOLD_W'(HOLD_STEPS - 1)) begin
                  idx_n   = colour_idx + 3'd1;
                  state_n = FADE;
               end else begin
                  hold_n = hold_cnt + HOLD_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FADE;
         pwm_cnt    <= '0;
         step_cnt   <= '0;
         hold_cnt   <= '0;
         colour_idx <= 3'd0;
         duty_r     <= '0;
         duty_g     <= '0;
         duty_b     <= '0;
         led_r      <= 1'b0;
         led_g      <= 1'b0;
         led_b      <= 1'b0;
      end else begin
         state      <= state_n;
         pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
         step_cnt   <= step_n;
         hold_cnt   <= hold_n;
         colour_idx <= idx_n;
         duty_r     <= duty_r_n;
         duty_g     <= duty_g_n;
         duty_b     <= duty_b_n;
         led_r      <= duty_r > pwm_cnt;
         led_g      <= duty_g > pwm_cnt;
         led_b      <= duty_b > pwm_cnt;
      end
   end

   assign holding = (state == HOLD);

endmodule
